// File: rtl/writeback_regfile.sv
// Result-bus sink: stages the selected writeback result for one cycle, commits it
// to an 8x16 register file, and tracks reserved-but-uncommitted destinations.
module writeback_regfile #(
  parameter int NREGS = 8,
  parameter int AW    = 3,
  parameter int DW    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wb_valid,
  input  logic [1:0]       wb_sel,
  input  logic [DW-1:0]    wb_data,
  input  logic [AW-1:0]    wb_dest,
  input  logic             mark_valid,
  input  logic [AW-1:0]    mark_dest,
  input  logic [AW-1:0]    rd_addr_a,
  input  logic [AW-1:0]    rd_addr_b,
  output logic [DW-1:0]    rd_data_a,
  output logic [DW-1:0]    rd_data_b,
  output logic [NREGS-1:0] pending,
  output logic             wb_err
);

  localparam logic [1:0] SEL_NONE = 2'b11;

  logic             vld_p1;
  logic [AW-1:0]    dest_p1;
  logic [DW-1:0]    data_p1;
  logic [DW-1:0]    regs [NREGS];
  logic             capture;
  logic             commit;
  logic [NREGS-1:0] pend_nxt;

  // Newest value wins: the staged result shadows the array until it commits.
  function automatic logic [DW-1:0] read_port(
    input logic          st_vld,
    input logic [AW-1:0] st_dest,
    input logic [DW-1:0] st_data,
    input logic [AW-1:0] addr,
    input logic [DW-1:0] arr_data
  );
    logic [DW-1:0] res;
    if (addr == '0)                       res = '0;
    else if (st_vld && st_dest == addr)   res = st_data;
    else                                  res = arr_data;
    return res;
  endfunction

  assign capture = wb_valid && (wb_sel != SEL_NONE);
  assign commit  = vld_p1 && (dest_p1 != '0);

  always_comb begin
    pend_nxt = pending;
    if (commit)
      pend_nxt[dest_p1] = 1'b0;
    // A same-edge reservation overrides the commit clear.
    if (mark_valid && mark_dest != '0)
      pend_nxt[mark_dest] = 1'b1;
    pend_nxt[0] = 1'b0;
  end

  // Stage p1: capture from the result bus
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1 <= 1'b0;
      wb_err <= 1'b0;
    end else begin
      vld_p1 <= capture;
      if (wb_valid && wb_sel == SEL_NONE)
        wb_err <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (capture) begin
      dest_p1 <= wb_dest;
      data_p1 <= wb_data;
    end
  end

  // Stage p2: commit into the array and update the scoreboard
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREGS; i++)
        regs[i] <= '0;
      pending <= '0;
    end else begin
      if (commit)
        regs[dest_p1] <= data_p1;
      pending <= pend_nxt;
    end
  end

  always_comb begin
    rd_data_a = read_port(vld_p1, dest_p1, data_p1, rd_addr_a, regs[rd_addr_a]);
    rd_data_b = read_port(vld_p1, dest_p1, data_p1, rd_addr_b, regs[rd_addr_b]);
  end

endmodule

// File: tb/tb_writeback_regfile.sv
// Directed bench for writeback_regfile: reset, bypass/commit timing, scoreboard,
// dropped no-source results and R0 handling.
module tb_writeback_regfile;

  logic        clk = 1'b0;
  logic        rst;
  logic        wb_valid;
  logic [1:0]  wb_sel;
  logic [15:0] wb_data;
  logic [2:0]  wb_dest;
  logic        mark_valid;
  logic [2:0]  mark_dest;
  logic [2:0]  rd_addr_a;
  logic [2:0]  rd_addr_b;
  logic [15:0] rd_data_a;
  logic [15:0] rd_data_b;
  logic [7:0]  pending;
  logic        wb_err;

  int checks = 0;
  int errors = 0;

  writeback_regfile #(.NREGS(8), .AW(3), .DW(16)) dut (
    .clk(clk), .rst(rst),
    .wb_valid(wb_valid), .wb_sel(wb_sel), .wb_data(wb_data), .wb_dest(wb_dest),
    .mark_valid(mark_valid), .mark_dest(mark_dest),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .pending(pending), .wb_err(wb_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge; inputs change 1 time unit after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_valid = 1'b0; wb_sel = 2'b00; wb_data = '0; wb_dest = '0;
    mark_valid = 1'b0; mark_dest = '0;
  endtask

  task automatic put(input logic [1:0] sel, input logic [15:0] data, input logic [2:0] dest);
    wb_valid = 1'b1; wb_sel = sel; wb_data = data; wb_dest = dest;
  endtask

  task automatic rd(input logic [2:0] a, input logic [2:0] b);
    rd_addr_a = a; rd_addr_b = b;
    #1;
  endtask

  initial begin
    idle();
    rst = 1'b1; rd_addr_a = '0; rd_addr_b = '0;
    step(); step();
    rst = 1'b0;

    // Test 1: reset state
    for (int i = 0; i < 8; i++) begin
      rd(3'(i), 3'(7 - i));
      chk("rst_rd_a", rd_data_a, 16'h0000);
      chk("rst_rd_b", rd_data_b, 16'h0000);
    end
    chk("rst_pending", pending, 8'h00);
    chk("rst_wb_err", wb_err, 1'b0);

    // Test 1b: staged write discarded by reset
    put(2'b00, 16'hAAAA, 3'd5);
    step();
    idle(); rst = 1'b1;
    step();
    rst = 1'b0;
    rd(3'd5, 3'd5);
    chk("rst_drop_r5", rd_data_a, 16'h0000);
    step();
    rd(3'd5, 3'd5);
    chk("rst_drop_r5_late", rd_data_b, 16'h0000);

    // Test 2: bypass then array read
    put(2'b00, 16'h1234, 3'd3);
    step();
    idle();
    rd(3'd3, 3'd0);
    chk("r3_bypass", rd_data_a, 16'h1234);
    step();
    rd(3'd3, 3'd3);
    chk("r3_commit_a", rd_data_a, 16'h1234);
    chk("r3_commit_b", rd_data_b, 16'h1234);
    step();
    rd(3'd3, 3'd0);
    chk("r3_hold", rd_data_a, 16'h1234);

    // Test 3: back-to-back writes to R2
    put(2'b10, 16'hFF80, 3'd2);
    step();
    put(2'b01, 16'h0042, 3'd2);
    rd(3'd2, 3'd3);
    chk("r2_mid", rd_data_a, 16'hFF80);
    chk("r3_other_port", rd_data_b, 16'h1234);
    step();
    idle();
    rd(3'd2, 3'd2);
    chk("r2_second_bypass", rd_data_a, 16'h0042);
    step();
    rd(3'd2, 3'd2);
    chk("r2_final_a", rd_data_a, 16'h0042);
    chk("r2_final_b", rd_data_b, 16'h0042);

    // Test 4: scoreboard
    mark_valid = 1'b1; mark_dest = 3'd4;
    step();
    idle();
    chk("pend_mark_r4", pending, 8'h10);
    put(2'b00, 16'h5555, 3'd4);
    step();
    idle();
    chk("pend_staged_r4", pending, 8'h10);
    step();
    chk("pend_commit_r4", pending, 8'h00);
    rd(3'd4, 3'd0);
    chk("r4_value", rd_data_a, 16'h5555);
    put(2'b00, 16'h6666, 3'd4);
    step();
    idle();
    mark_valid = 1'b1; mark_dest = 3'd4;
    step();
    idle();
    chk("pend_mark_wins", pending, 8'h10);
    put(2'b01, 16'h0777, 3'd6);
    step();
    idle();
    step();
    chk("pend_unmarked_commit", pending, 8'h10);
    rd(3'd6, 3'd4);
    chk("r6_value", rd_data_a, 16'h0777);
    chk("r4_second", rd_data_b, 16'h6666);

    // Test 5: no-source result dropped and flagged
    put(2'b11, 16'hBEEF, 3'd1);
    step();
    idle();
    chk("err_set", wb_err, 1'b1);
    rd(3'd1, 3'd1);
    chk("r1_not_bypassed", rd_data_a, 16'h0000);
    step(); step();
    rd(3'd1, 3'd1);
    chk("r1_unchanged", rd_data_b, 16'h0000);
    chk("err_sticky", wb_err, 1'b1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("err_cleared", wb_err, 1'b0);
    chk("pend_cleared", pending, 8'h00);

    // Test 6: R0 writes and marks
    put(2'b00, 16'hFFFF, 3'd0);
    mark_valid = 1'b1; mark_dest = 3'd0;
    step();
    idle();
    rd(3'd0, 3'd0);
    chk("r0_staged_a", rd_data_a, 16'h0000);
    chk("r0_staged_b", rd_data_b, 16'h0000);
    chk("r0_pending", pending, 8'h00);
    step();
    rd(3'd0, 3'd0);
    chk("r0_after_a", rd_data_a, 16'h0000);
    chk("r0_after_b", rd_data_b, 16'h0000);
    chk("r0_pending_after", pending, 8'h00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
